alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (4-bit ALUOp encoding, 32-bit signed operands) among NUM_REQ requesters, e.g. core execute stage plus a debug/accelerator port.
- Per-requester valid/ready request and response channels.
- Round-robin grant; operands and result are registered, so the ALU input cone is isolated from requester logic.
- Sits between the requesters and the ALU instance; this block drives the ALU's A/B/ALUOp inputs and samples ALURes.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..4
DATA_W, 32, operand/result width; must match the ALU

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept strobe
req_a  input  NUM_REQ*DATA_W  packed operand A, requester i at bits [i*DATA_W +: DATA_W]
req_b  input  NUM_REQ*DATA_W  packed operand B, same packing
req_op  input  NUM_REQ*4  packed ALUOp, requester i at bits [i*4 +: 4]
alu_a  output  DATA_W  to ALU A
alu_b  output  DATA_W  to ALU B
alu_op  output  4  to ALU ALUOp
alu_res  input  DATA_W  from ALU ALURes
rsp_valid  output  NUM_REQ  response valid, one-hot or zero
rsp_data  output  DATA_W  response result, shared by all requesters
rsp_ready  input  NUM_REQ  per-requester response accept

Behaviour:
- FSM with three states:
  - IDLE -> ISSUE when any req_valid is high.
  - ISSUE -> RESP unconditionally.
  - RESP -> IDLE on rsp_valid[g] & rsp_ready[g].
- Grant, combinational in IDLE:
  - g = first i with req_valid[i] set, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[g] = 1 only in IDLE; all other req_ready are 0.
  - req_ready never asserts without the matching req_valid.
- Accept cycle T (IDLE, handshake):
  - Capture req_a[g], req_b[g], req_op[g] into op_a, op_b, op_opc.
  - Capture g into grant_q.
- alu_a/alu_b/alu_op are driven directly from op_a/op_b/op_opc at all times, so they are stable for a full cycle in ISSUE.
- ISSUE (T+1): capture alu_res into res_q.
- RESP (T+2 onward):
  - rsp_valid[grant_q] = 1 and rsp_data = res_q.
  - Both are held stable until rsp_ready[grant_q] is high.
  - On handshake, last_grant <= grant_q.
- Latency and throughput: accept to rsp_valid is 2 cycles; at most one op in flight; maximum 1 op per 3 cycles with rsp_ready high.
- ALUOp values are passed through unmodified, including unused encodings. Result equals ALU output, e.g. ADD 0000, SUB 1000, SLTU 0011, SRA 1101, PASS_B 1001.
- rsp_data is 0 outside RESP.
- req_valid changes while not in IDLE are ignored; no request is lost, because its requester sees no ready.
- A requester that deasserts req_valid before a grant is simply not served.
- Reset values, applied on the next clk edge with rst=1 from any state (in-flight op is discarded, no response):
  - state = IDLE
  - last_grant = NUM_REQ-1, so requester 0 has first priority
  - op_a = op_b = 0, op_opc = 0 (alu outputs 0)
  - res_q = 0, grant_q = 0
  - all rsp_valid = 0, all req_ready = 0
- While rst is high, req_ready is forced to 0.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins (g = lowest i with req_valid[i]); last_grant is not used.
- Undefined (default): round-robin as above.
- All other timing is identical in both cases.

Test Plan:
- Req0 only, A=5 B=7 op=0000 at cycle T -> req_ready[0]=1 at T, rsp_valid[0]=1 at T+2 with rsp_data=12, alu_a=5 during T+1.
- Req0 and Req1 held valid continuously with op=1000 (SUB), rsp_ready held high -> grants 0,1,0,1 on accept cycles 3 apart; each rsp_data is the requester's own A-B.
- Backpressure: Req1 A=-1 B=1 op=0011 (SLTU), rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and rsp_data=0 held stable, req_ready all 0 despite req_valid[0]=1; released -> IDLE next cycle and req0 is granted.
- SRA check: A=0x80000000 B=4 op=1101 -> 0xF8000000; op=1001 with B=0x1234 -> 0x1234.
- rst=1 during ISSUE -> next cycle state IDLE, rsp_valid=0, alu_a=0; with both valid afterwards, req0 is granted first.
- With ALU_ARB_FIXED_PRIO_EN defined, both requesters continuously valid -> req0 wins every accept; req1 is served only when req_valid[0]=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one shared combinational ALU, round-robin grant (lowest index wins if ALU_ARB_FIXED_PRIO_EN).
// Latency: accept -> rsp_valid 2 cycles, one op in flight, at most one op per 3 cycles.
// Backpressure: response held until rsp_ready; req_ready stays low outside IDLE so no request is lost.
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    input  logic [NUM_REQ*4-1:0]        req_op,
    output logic [DATA_W-1:0]           alu_a,
    output logic [DATA_W-1:0]           alu_b,
    output logic [3:0]                  alu_op,
    input  logic [DATA_W-1:0]           alu_res,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    input  logic [NUM_REQ-1:0]          rsp_ready
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [GW-1:0]     grant;
    logic              grant_found;
    logic [GW-1:0]     grant_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [3:0]        op_opc;
    logic [DATA_W-1:0] res_q;
    logic              accept;
    logic              rsp_done;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest valid index is the last (winning) write.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant       = GW'(i);
                grant_found = 1'b1;
            end
        end
    end
`else
    logic [GW-1:0] last_grant;

    always_comb begin
        int idx;
        grant       = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant       = GW'(idx);
                grant_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GW'(NUM_REQ - 1);
        end else if (rsp_done) begin
            last_grant <= grant_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        accept    = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && grant_found) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_nxt        = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                rsp_data           = res_q;
                if (rsp_ready[grant_q]) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand registers isolate the ALU input cone from requester logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            op_opc  <= '0;
            grant_q <= '0;
            res_q   <= '0;
        end else begin
            if (accept) begin
                op_a    <= req_a[grant*DATA_W +: DATA_W];
                op_b    <= req_b[grant*DATA_W +: DATA_W];
                op_opc  <= req_op[grant*4 +: 4];
                grant_q <= grant;
            end
            if (state == ISSUE) begin
                res_q <= alu_res;
            end
        end
    end

    assign alu_a  = op_a;
    assign alu_b  = op_b;
    assign alu_op = op_opc;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized plus directed bench for alu_share_arbiter with a transaction-level reference model and a behavioural ALU.
module tb_alu_share_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N*4-1:0]  req_op;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [3:0]      alu_op;
    logic [DW-1:0]   alu_res;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [N-1:0]    rsp_ready;

    int total = 0;
    int bad   = 0;

    // Reference model: one transaction record plus the round-robin pointer.
    bit          m_busy;
    int          m_age;
    int          m_req;
    int          m_last;
    logic [31:0] m_a, m_b, m_res;
    logic [3:0]  m_op;

    alu_share_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'b0, $signed(a) < $signed(b)};
            4'b0011: return {31'b0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return 32'($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b1001: return b;
            default: return 32'h0;
        endcase
    endfunction

    assign alu_res = alu_fn(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (v[(m_last + k) % N]) return (m_last + k) % N;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_req = 0; m_last = N - 1;
        m_a = 0; m_b = 0; m_op = 0; m_res = 0;
    endtask

    task automatic model_check();
        logic [N-1:0] e_rdy, e_rv;
        logic [31:0]  e_rd;
        int g;
        e_rdy = '0; e_rv = '0; e_rd = '0;
        if (!rst && !m_busy) begin
            g = pick(req_valid);
            if (g >= 0) e_rdy[g] = 1'b1;
        end
        if (m_busy && m_age >= 2) begin
            e_rv[m_req] = 1'b1;
            e_rd = m_res;
        end
        check("req_ready", 64'(req_ready), 64'(e_rdy));
        check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        check("rsp_data",  64'(rsp_data),  64'(e_rd));
        check("alu_a",     64'(alu_a),     64'(m_a));
        check("alu_b",     64'(alu_b),     64'(m_b));
        check("alu_op",    64'(alu_op),    64'(m_op));
    endtask

    task automatic model_advance();
        int g;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            g = pick(req_valid);
            if (g >= 0) begin
                m_busy = 1; m_age = 1; m_req = g;
                m_a  = req_a[g*DW +: DW];
                m_b  = req_b[g*DW +: DW];
                m_op = req_op[g*4 +: 4];
                m_res = alu_fn(m_a, m_b, m_op);
            end
        end else if (m_age >= 2) begin
            if (rsp_ready[m_req]) begin
                m_busy = 0;
                m_last = m_req;
            end
        end else begin
            m_age++;
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] v,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] o0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] o1,
                        input logic [N-1:0] rr);
        @(posedge clk);
        #1;
        rst = r; req_valid = v; rsp_ready = rr;
        req_a = {a1, a0}; req_b = {b1, b0}; req_op = {o1, o0};
        @(negedge clk);
        model_check();
        model_advance();
    endtask

    task automatic do_reset();
        step(1'b1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11);
        step(1'b1, 2'b11, 0, 0, 0, 0, 0, 0, 2'b11);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_alu_a", 64'(alu_a), 64'h0);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state and single ADD from requester 0.
        do_reset();
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_data", 64'(rsp_data), 64'h0);
        step(1'b0, 2'b01, 5, 7, 4'b0000, 0, 0, 0, 2'b11);
        check("add_ready", 64'(req_ready), 64'h1);
        step(1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11);
        check("add_alu_a", 64'(alu_a), 64'd5);
        step(1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11);
        check("add_rsp_valid", 64'(rsp_valid), 64'h1);
        check("add_rsp_data", 64'(rsp_data), 64'd12);

        // Both requesters valid, SUB; grants alternate (or stick to 0 with fixed priority).
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 2'b11, 100, 30, 4'b1000, 50, 80, 4'b1000, 2'b11);
            if (i % 3 == 0) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                check("fix_grant", 64'(req_ready), 64'h1);
`else
                check("rr_grant", 64'(req_ready), (i % 6 == 0) ? 64'h1 : 64'h2);
`endif
            end
            if (i == 2) check("sub_rsp0", 64'(rsp_data), 64'd70);
        end
        step(1'b0, 2'b10, 0, 0, 0, 50, 80, 4'b1000, 2'b11);

        // Backpressure on requester 1 while requester 0 waits.
        do_reset();
        step(1'b0, 2'b10, 0, 0, 0, 32'hFFFF_FFFF, 1, 4'b0011, 2'b00);
        check("bp_accept", 64'(req_ready), 64'h2);
        step(1'b0, 2'b01, 9, 9, 4'b0000, 0, 0, 0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'b01, 9, 9, 4'b0000, 0, 0, 0, 2'b00);
            check("bp_rsp_valid", 64'(rsp_valid), 64'h2);
            check("bp_rsp_data", 64'(rsp_data), 64'h0);
            check("bp_no_ready", 64'(req_ready), 64'h0);
        end
        step(1'b0, 2'b01, 9, 9, 4'b0000, 0, 0, 0, 2'b10);
        step(1'b0, 2'b01, 9, 9, 4'b0000, 0, 0, 0, 2'b11);
        check("bp_req0_grant", 64'(req_ready), 64'h1);
        step(1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11);
        step(1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11);

        // SRA and PASS_B.
        do_reset();
        step(1'b0, 2'b01, 32'h8000_0000, 4, 4'b1101, 0, 0, 0, 2'b11);
        step(1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11);
        step(1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11);
        check("sra", 64'(rsp_data), 64'hF800_0000);
        step(1'b0, 2'b10, 0, 0, 0, 32'h55, 32'h1234, 4'b1001, 2'b11);
        step(1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11);
        step(1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11);
        check("pass_b", 64'(rsp_data), 64'h1234);

        // Reset during ISSUE discards the op; requester 0 then wins.
        step(1'b0, 2'b10, 0, 0, 0, 3, 4, 4'b0000, 2'b11);
        step(1'b1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11);
        step(1'b0, 2'b11, 1, 2, 4'b0000, 3, 4, 4'b0000, 2'b11);
        check("rst_issue_rv", 64'(rsp_valid), 64'h0);
        check("rst_issue_alu", 64'(alu_a), 64'h0);
        check("rst_issue_grant", 64'(req_ready), 64'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), N'($urandom),
                 $urandom, $urandom, 4'($urandom), $urandom, $urandom, 4'($urandom),
                 ($urandom_range(0, 3) != 0) ? 2'b11 : N'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
